reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the MIPS decode stage; next generation of the 2-read/1-write bank.
- Adds configurable read-port count, a second write port with defined collision priority, and hardwired register 0.
- Adds a serial debug dump engine with valid/ready handshake that streams every register to a monitor/UART without stalling the pipeline.

---
 rtl/reg_file_mp.sv | 122 ++++++++++++
 tb/tb_reg_file_mp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardwired-zero option and debug dump engine; REGFILE_BYPASS_EN adds write-first reads.
// Latency: reads combinational; writes visible next cycle (same cycle with bypass); dump beat 1 cycle after dump_start.
// Backpressure: dump beats hold under dump_ready=0; pipeline reads/writes are never stalled by the dump.
module reg_file_mp #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_READ      = 2,
    parameter int ZERO_REG      = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              we0,
    input  logic [ADDRESS_WIDTH-1:0]          addressW0,
    input  logic [DATA_WIDTH-1:0]             data0,
    input  logic                              we1,
    input  logic [ADDRESS_WIDTH-1:0]          addressW1,
    input  logic [DATA_WIDTH-1:0]             data1,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] addressR,
    output logic [NUM_READ*DATA_WIDTH-1:0]    regR,
    input  logic                              dump_start,
    input  logic                              dump_ready,
    output logic                              dump_valid,
    output logic [ADDRESS_WIDTH-1:0]          dump_addr,
    output logic [DATA_WIDTH-1:0]             dump_data,
    output logic                              dump_busy,
    output logic                              dump_done
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} dumpState_t;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    dumpState_t               state, stateNext;
    logic [ADDRESS_WIDTH-1:0] ptr, ptrNext, captAddr;
    logic [DATA_WIDTH-1:0]    dumpDataQ, dumpDataNext, captData;
    logic                     keep0, keep1;

    assign keep0 = we0 && !(ZERO_REG != 0 && addressW0 == '0);
    assign keep1 = we1 && !(ZERO_REG != 0 && addressW1 == '0);

    // Port 1 is written last so it overrides port 0 on an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (keep0) mem[addressW0] <= data0;
            if (keep1) mem[addressW1] <= data1;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDRESS_WIDTH-1:0] rAddr;
        logic [DATA_WIDTH-1:0]    rData;
        always_comb begin
            rAddr = addressR[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            rData = mem[rAddr];
`ifdef REGFILE_BYPASS_EN
            if (we0 && addressW0 == rAddr) rData = data0;
            if (we1 && addressW1 == rAddr) rData = data1;
`endif
            if (ZERO_REG != 0 && rAddr == '0) rData = '0;
        end
        assign regR[k*DATA_WIDTH +: DATA_WIDTH] = rData;
    end

    // Value the register will hold after this edge, so a beat sees same-edge writes.
    always_comb begin
        captAddr = (state == IDLE) ? '0 : ptr + 1'b1;
        captData = mem[captAddr];
        if (we0 && addressW0 == captAddr) captData = data0;
        if (we1 && addressW1 == captAddr) captData = data1;
        if (ZERO_REG != 0 && captAddr == '0) captData = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            dumpDataQ <= '0;
        end else begin
            state     <= stateNext;
            ptr       <= ptrNext;
            dumpDataQ <= dumpDataNext;
        end
    end

    always_comb begin
        stateNext    = state;
        ptrNext      = ptr;
        dumpDataNext = dumpDataQ;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    stateNext    = STREAM;
                    ptrNext      = '0;
                    dumpDataNext = captData;
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (ptr == '1) begin
                        stateNext = DONE;
                    end else begin
                        ptrNext      = captAddr;
                        dumpDataNext = captData;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
                ptrNext   = '0;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign dump_valid = (state == STREAM);
    assign dump_addr  = ptr;
    assign dump_data  = dumpDataQ;
    assign dump_busy  = (state != IDLE);
    assign dump_done  = (state == DONE);
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomized bench for reg_file_mp against an array-based reference model.
// All drives and samples happen 1-2 time units after the rising edge.
module tb_reg_file_mp;
    localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, we0, we1;
    logic [AW-1:0]    addressW0, addressW1;
    logic [DW-1:0]    data0, data1;
    logic [NR*AW-1:0] addressR;
    logic [NR*DW-1:0] regR;
    logic             dumpStart, dumpReady, dumpValid, dumpBusy, dumpDone;
    logic [AW-1:0]    dumpAddr;
    logic [DW-1:0]    dumpData;

    logic [AW-1:0]    zAddrR;
    logic [DW-1:0]    zRegR;
    logic             zStart, zReady, zValid, zBusy, zDone;
    logic [AW-1:0]    zAddr;
    logic [DW-1:0]    zData;

    int nAssert = 0;
    int nFail   = 0;
    logic [DW-1:0] model [DEPTH];

    reg_file_mp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .addressW0(addressW0), .data0(data0),
        .we1(we1), .addressW1(addressW1), .data1(data1),
        .addressR(addressR), .regR(regR),
        .dump_start(dumpStart), .dump_ready(dumpReady), .dump_valid(dumpValid),
        .dump_addr(dumpAddr), .dump_data(dumpData), .dump_busy(dumpBusy), .dump_done(dumpDone)
    );

    // Same write traffic, register 0 as ordinary storage.
    reg_file_mp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_READ(1), .ZERO_REG(0)) dutZ (
        .clk(clk), .reset(reset),
        .we0(we0), .addressW0(addressW0), .data0(data0),
        .we1(we1), .addressW1(addressW1), .data1(data1),
        .addressR(zAddrR), .regR(zRegR),
        .dump_start(zStart), .dump_ready(zReady), .dump_valid(zValid),
        .dump_addr(zAddr), .dump_data(zData), .dump_busy(zBusy), .dump_done(zDone)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, updating the model from the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else begin
            if (we0 && addressW0 != 0) model[addressW0] = data0;
            if (we1 && addressW1 != 0) model[addressW1] = data1;
        end
        #1;
    endtask

    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && addressW1 == a) return data1;
        if (we0 && addressW0 == a) return data0;
`endif
        return model[a];
    endfunction

    initial begin
        int beats, gaps, doneAt, doneCnt;
        logic [AW-1:0] ra0, ra1;

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        reset = 1'b0; we1 = 1'b0; addressW1 = '0; data1 = '0;
        we0 = 1'b1; addressW0 = 5'd2; data0 = 32'hF;
        addressR = '0; dumpStart = 1'b0; dumpReady = 1'b0;
        zAddrR = '0; zStart = 1'b0; zReady = 1'b1;
        step(); step();

        // Reset dominates a write.
        we0 = 1'b0; addressR = {5'd2, 5'd2}; #1;
        chk("reset_reg2", regR[31:0], 64'h0);
        chk("reset_dump_outs", {dumpValid, dumpBusy, dumpDone, dumpAddr, dumpData}, 64'h0);

        reset = 1'b1;
        we0 = 1'b1; addressW0 = 5'd2; data0 = 32'h8;
        step();
        we0 = 1'b0; #1;
        chk("write_reg2", regR[31:0], 64'h8);

        // Same-address collision: port 1 wins.
        we0 = 1'b1; we1 = 1'b1; addressW0 = 5'd3; addressW1 = 5'd3;
        data0 = 32'h5; data1 = 32'hA; addressR = {5'd3, 5'd3}; #1;
`ifdef REGFILE_BYPASS_EN
        chk("coll_same_cycle", regR[31:0], 64'hA);
`else
        chk("coll_same_cycle", regR[31:0], 64'h0);
`endif
        step();
        we0 = 1'b0; we1 = 1'b0; #1;
        chk("coll_after", regR[63:32], 64'hA);

        // Register 0 hardwired to zero, ordinary in dutZ.
        we0 = 1'b1; we1 = 1'b1; addressW0 = '0; addressW1 = '0;
        data0 = 32'hDEAD; data1 = 32'hDEAD; addressR = '0; #1;
        chk("zero_same_cycle", regR, 64'h0);
        step();
        we0 = 1'b0; we1 = 1'b0; #1;
        chk("zero_rd_ports", regR, 64'h0);
        chk("zero_off_reads", zRegR, 64'hDEAD);

        // Randomized reads/writes against the model.
        for (int n = 0; n < 300; n++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            addressW0 = 5'($urandom); data0 = $urandom; data1 = $urandom;
            addressW1 = ($urandom_range(3) == 0) ? addressW0 : 5'($urandom);
            ra0 = 5'($urandom);
            ra1 = ($urandom_range(1) == 0) ? addressW1 : 5'($urandom);
            addressR = {ra1, ra0}; #1;
            chk($sformatf("rand_rd0_%0d", n), regR[31:0], expRead(ra0));
            chk($sformatf("rand_rd1_%0d", n), regR[63:32], expRead(ra1));
            step();
        end
        we0 = 1'b0; we1 = 1'b0;

        // Preload mem[i] = i*3.
        for (int i = 0; i < DEPTH; i++) begin
            we0 = 1'b1; addressW0 = AW'(i); data0 = DW'(i * 3);
            step();
        end
        we0 = 1'b0;

        // Full dump with ready held high; the request cycle plus DEPTH+1 edges gives DEPTH+2 cycles.
        beats = 0; gaps = 0; doneAt = 0; doneCnt = 0;
        dumpReady = 1'b1; dumpStart = 1'b1;
        for (int c = 1; c <= DEPTH + 6; c++) begin
            step();
            dumpStart = 1'b0;
            if (dumpValid) begin
                chk($sformatf("full_beat_%0d", beats), {dumpAddr, dumpData}, {AW'(beats), DW'(beats * 3)});
                if (c != beats + 1) gaps++;
                beats++;
            end
            if (dumpDone) begin
                doneCnt++;
                doneAt = c;
            end
        end
        chk("full_beats", beats, DEPTH);
        chk("full_gaps", gaps, 0);
        chk("full_done_count", doneCnt, 1);
        chk("full_done_latency", doneAt + 1, DEPTH + 2);
        chk("full_busy_after", dumpBusy, 0);

        // Stall at beat 7 while register 7 is rewritten and dump_start is retriggered.
        dumpReady = 1'b1; dumpStart = 1'b1;
        step();
        dumpStart = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("stall_beat7", {dumpValid, dumpAddr, dumpData}, {1'b1, 5'd7, 32'd21});
        dumpReady = 1'b0;
        for (int s = 0; s < 5; s++) begin
            we0 = (s == 0); addressW0 = 5'd7; data0 = 32'h77;
            dumpStart = (s == 2);
            step();
            we0 = 1'b0; dumpStart = 1'b0;
            chk($sformatf("stall_hold_%0d", s), {dumpValid, dumpAddr, dumpData}, {1'b1, 5'd7, 32'd21});
        end
        addressR = {5'd7, 5'd7}; #1;
        chk("stall_reg7_written", regR[31:0], 64'h77);
        dumpReady = 1'b1;
        step();
        chk("stall_beat8", {dumpValid, dumpAddr, dumpData}, {1'b1, 5'd8, 32'd24});
        for (int i = 9; i < DEPTH; i++) begin
            step();
            chk($sformatf("stall_beat_%0d", i), {dumpValid, dumpAddr, dumpData}, {1'b1, AW'(i), DW'(i * 3)});
        end
        step();
        chk("stall_done", {dumpDone, dumpValid}, 2'b10);
        step();
        chk("stall_idle", {dumpBusy, dumpDone}, 2'b00);

        // Reset in the middle of a dump.
        dumpStart = 1'b1;
        step();
        dumpStart = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("rst_beat12", {dumpValid, dumpAddr, dumpData}, {1'b1, 5'd12, 32'd36});
        #2 reset = 1'b0;
        #1;
        chk("rst_async_outs", {dumpValid, dumpBusy, dumpDone, dumpAddr, dumpData}, 64'h0);
        doneCnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (dumpDone) doneCnt++;
        end
        chk("rst_no_done", doneCnt, 0);
        for (int a = 0; a < DEPTH; a += 2) begin
            addressR = {AW'(a + 1), AW'(a)}; #1;
            chk($sformatf("rst_regs_%0d", a), regR, 64'h0);
        end
        reset = 1'b1; dumpReady = 1'b1; dumpStart = 1'b1;
        step();
        dumpStart = 1'b0;
        chk("restart_beat0", {dumpValid, dumpAddr, dumpData}, {1'b1, 5'd0, 32'd0});
        doneCnt = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            step();
            if (dumpDone) doneCnt++;
        end
        chk("restart_done_once", doneCnt, 1);
        chk("zinst_dump_quiet", {zValid, zBusy, zDone, zAddr, zData}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
